ppu_feed_sched: RTL

// Scheduler that sequences and shares the PPU 8-bit strobe/ack input port between two requesters.
// The line-fetch source streams BUF_NUM bytes per line for LINES lines after each frame sync.
// The host/config source fills gaps between lines and idle time.

---
 rtl/ppu_feed_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ppu_feed_sched.sv
// Shares the PPU strobe/ack byte port between line fetch and host traffic.
// Tracks frame/line position and flags ack timeouts and sync overruns.
module ppu_feed_sched #(
  parameter int BUF_NUM = 32,
  parameter int LINES   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync,
  input  logic [2:0]               mode,
  input  logic [7:0]               fetch_data,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [7:0]               host_data,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [7:0]               ppu_data,
  output logic                     ppu_stb,
  input  logic                     ppu_ack,
  output logic [$clog2(LINES)-1:0] line_idx,
  output logic                     busy,
  output logic                     frame_done,
  output logic [1:0]               err
);

  localparam int LW = $clog2(LINES);
  localparam int BW = $clog2(BUF_NUM);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, FETCH, GAP, XFER
  } state_e;

  state_e      state_q;
  logic        sync_q;
  logic        src_fetch_q;
  logic        gap_used_q;
  logic        restart_q;
  logic        busy_q;
  logic        stb_q;
  logic        done_q;
  logic [7:0]  data_q;
  logic [LW-1:0] line_q;
  logic [BW-1:0] byte_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]  err_q;

  logic fetch_en, sync_rise, start_idle;
  logic abort, new_frame, restart;
  logic fetch_cap, host_cap;
  logic last_byte, last_line, tmo_hit;

  assign fetch_en   = (mode != 3'd0);
  assign sync_rise  = sync & ~sync_q;
  assign start_idle = (state_q == IDLE) & sync_rise & fetch_en;
  assign abort      = sync_rise & busy_q;
  // a host byte sent from idle defers a new frame until it completes
  assign new_frame  = sync_rise & fetch_en & (state_q == XFER) & ~busy_q;
  assign restart    = restart_q | abort | new_frame;

  assign fetch_ready = (state_q == FETCH) & ~stb_q;
  assign host_ready  = ~stb_q &
                       (((state_q == IDLE) & ~start_idle) |
                        ((state_q == GAP) & ~gap_used_q));

  assign fetch_cap = fetch_valid & fetch_ready;
  assign host_cap  = host_valid & host_ready;
  assign last_byte = (byte_q == BW'(BUF_NUM - 1));
  assign last_line = (line_q == LW'(LINES - 1));
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

  assign ppu_data   = data_q;
  assign ppu_stb    = stb_q;
  assign line_idx   = line_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 1'b0;
      src_fetch_q <= 1'b0;
      gap_used_q  <= 1'b0;
      restart_q   <= 1'b0;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      line_q      <= '0;
      byte_q      <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
    end else begin
      sync_q <= sync;
      done_q <= 1'b0;
      if (abort) err_q[1] <= 1'b1;
      if (abort || new_frame) restart_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start_idle) begin
            state_q <= FETCH;
            line_q  <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
          end else if (host_cap) begin
            data_q      <= host_data;
            stb_q       <= 1'b1;
            src_fetch_q <= 1'b0;
            state_q     <= XFER;
          end
        end
        FETCH: begin
          if (fetch_cap) begin
            data_q      <= fetch_data;
            stb_q       <= 1'b1;
            src_fetch_q <= 1'b1;
            state_q     <= XFER;
          end else if (restart) begin
            line_q    <= '0;
            byte_q    <= '0;
            restart_q <= 1'b0;
          end
        end
        GAP: begin
          if (host_cap) begin
            data_q      <= host_data;
            stb_q       <= 1'b1;
            src_fetch_q <= 1'b0;
            state_q     <= XFER;
          end else if (restart) begin
            line_q    <= '0;
            byte_q    <= '0;
            restart_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end else begin
            state_q <= fetch_en ? FETCH : IDLE;
            busy_q  <= fetch_en;
          end
        end
        XFER: begin
          if (ppu_ack || tmo_hit) begin
            stb_q <= 1'b0;
            tmo_q <= '0;
            if (!ppu_ack) err_q[0] <= 1'b1;
            if (restart) begin
              line_q    <= '0;
              byte_q    <= '0;
              restart_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= FETCH;
            end else if (!ppu_ack) begin
              // dropped byte: counters untouched
              state_q <= src_fetch_q ? FETCH : IDLE;
              if (!src_fetch_q) busy_q <= 1'b0;
            end else if (src_fetch_q) begin
              if (last_byte) begin
                byte_q     <= '0;
                gap_used_q <= 1'b0;
                if (last_line) begin
                  line_q  <= '0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end else begin
                  line_q  <= line_q + LW'(1);
                  busy_q  <= fetch_en;
                  state_q <= fetch_en ? GAP : IDLE;
                end
              end else begin
                byte_q  <= byte_q + BW'(1);
                state_q <= FETCH;
              end
            end else if (byte_q == '0 && line_q != '0) begin
              gap_used_q <= 1'b1;
              state_q    <= GAP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
